// File: rtl/cdru_arb.sv
// N-requestor bank-conflict read arbiter with starvation promotion; grant is same-cycle, o_* one cycle later.
// No backpressure: denied requestors hold their request, and the counters lift them to top priority.
module cdru_arb #(
  parameter int NREQ     = 3,
  parameter int BANKBITS = 5,
  parameter int WORDBITS = 9,
  parameter int STARVE   = 4,
  localparam int A       = BANKBITS + WORDBITS,
  localparam int SELW    = ($clog2(NREQ) > 1) ? $clog2(NREQ) : 1,
  localparam int CNTW    = $clog2(STARVE + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   r_en,
  input  logic [NREQ*A-1:0] r_addr,
  output logic [NREQ-1:0]   r_grnt,
  output logic              o_en,
  output logic [A-1:0]      o_addr,
  output logic [SELW-1:0]   o_sel,
  output logic [NREQ-1:0]   o_gmask
);

  logic [CNTW-1:0]     cnt [NREQ];
  logic [BANKBITS-1:0] bank [NREQ];
  logic [NREQ-1:0]     starving;
  logic [NREQ-1:0]     grnt;
  logic                prim_found;
  logic [SELW-1:0]     prim_idx;
  logic                clash;

  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      bank[k]     = r_addr[k*A+WORDBITS +: BANKBITS];
      starving[k] = (cnt[k] == CNTW'(STARVE));
    end
  end

  // Pass 0 walks the starving requestors, pass 1 the rest; both in ascending index.
  always_comb begin
    grnt       = '0;
    prim_found = 1'b0;
    prim_idx   = '0;
    clash      = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (r_en[k] && (starving[k] == (pass == 0))) begin
          clash = 1'b0;
          for (int j = 0; j < NREQ; j++) begin
            if (grnt[j] && (bank[j] == bank[k]))
              clash = 1'b1;
          end
          if (!clash) begin
            grnt[k] = 1'b1;
            if (!prim_found) begin
              prim_found = 1'b1;
              prim_idx   = SELW'(k);
            end
          end
        end
      end
    end
  end

  assign r_grnt = grnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREQ; k++)
        cnt[k] <= '0;
      o_en    <= 1'b0;
      o_addr  <= '0;
      o_sel   <= '0;
      o_gmask <= '0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (r_en[k] && !grnt[k])
          cnt[k] <= starving[k] ? cnt[k] : cnt[k] + 1'b1;
        else
          cnt[k] <= '0;
      end
      o_gmask <= grnt;
      o_en    <= |grnt;
      if (prim_found) begin
        o_addr <= r_addr[prim_idx*A +: A];
        o_sel  <= prim_idx;
      end
    end
  end

endmodule
